alm_product_accumulator: RTL and testbench
==========================================

// Module: alm_product_accumulator
// PURPOSE
//   Streaming dot-product accumulator sitting directly downstream of the signed ALM multipliers
//   (enhanced / hybrid / iterative). Consumes one signed 16-bit approximate product per beat over a
//   valid/ready handshake. Sums VEC_LEN products, or fewer if i_last is asserted, with saturation.
//   Presents the registered sum, beat count and sticky overflow flag on a valid/ready output port.
// PARAMETERS
//   PROD_WIDTH  16  width of signed product input (matches multiplier o_z)
//   ACC_WIDTH   24  width of signed accumulator / o_sum; must be >= PROD_WIDTH
//   VEC_LEN     64  max beats per vector; vector closes automatically at this count
//   CNT_WIDTH   $clog2(VEC_LEN+1)  width of beat counter / o_count
// PORTS
//   i_clk    in   1           clock, rising edge
//   i_rst    in   1           asynchronous active-high reset
//   i_prod   in   PROD_WIDTH  signed product from multiplier
//   i_valid  in   1           i_prod / i_last valid
//   i_last   in   1           current beat is final beat of vector
//   o_ready  out  1           block can accept a beat this cycle
//   o_sum    out  ACC_WIDTH   signed saturated vector sum
//   o_count  out  CNT_WIDTH   number of beats summed into o_sum
//   o_ovf    out  1           saturation occurred at least once in this vector
//   o_valid  out  1           o_sum / o_count / o_ovf valid
//   i_ready  in   1           downstream accepts result
// BEHAVIOUR
//   - Reset (async, any cycle, including mid-vector): state=IDLE, acc=0, count=0, ovf=0.
//     Outputs: o_sum=0, o_count=0, o_ovf=0, o_valid=0, o_ready=0 while i_rst high, o_ready=1 in the first cycle after.
//     A partial sum is discarded.
//   - FSM states: IDLE (no beats yet), ACCUM (>=1 beat taken), DONE (result held).
//   - o_ready = (state != DONE); registered-state decode only, no combinational path from i_ready.
//   - Beat accepted when i_valid && o_ready. i_prod is sign-extended to ACC_WIDTH+1.
//     The first beat in IDLE loads the sum as 0+i_prod, i.e. it starts a fresh vector.
//   - Saturating add: if the true sum exceeds +(2^(ACC_WIDTH-1)-1) or falls below -2^(ACC_WIDTH-1),
//     clamp to that bound and set ovf (sticky until the next vector starts).
//   - count increments per accepted beat.
//     Vector closes on the accepted beat where i_last=1 OR count+1 == VEC_LEN.
//   - Transitions:
//     IDLE->ACCUM on an accepted beat that does not close the vector.
//     IDLE->DONE on an accepted beat that closes it (single-beat vector).
//     ACCUM->DONE on the closing beat.
//     DONE->IDLE when i_ready=1.
//   - Latency: o_valid rises the cycle after the closing beat is accepted.
//   - In DONE: o_sum/o_count/o_ovf are stable while o_valid && !i_ready.
//     On the handshake cycle they drop to o_valid=0 next cycle; o_ready returns 1 that same next cycle.
//     One bubble cycle per vector, with no input/output bypass.
//   - i_last with i_valid=0 is ignored. i_prod is ignored when not accepted.
//   - count never wraps: maximum VEC_LEN, which fits CNT_WIDTH.
//   - Zero products (either multiplier operand 0) are ordinary beats and do count.
// STRUCTURE
//   - alm_pkg (shared): typedef enum logic [1:0] {ACC_IDLE, ACC_ACCUM, ACC_DONE} acc_state_t;
//     localparam ALM_PROD_WIDTH = 16.
//   - Sub-module alm_sat_add #(IN_W, ACC_W): combinational signed saturating adder.
//     Outputs are sum and sat flag. It is reused by any future tree-reduction stage.
//   - Top: FSM, acc/count/ovf registers, output registers. No memories.
// TESTING
//   - Reset then 4 beats {100,-50,7,3}, last on beat 4, i_ready=1
//     -> o_valid one cycle after beat 4; o_sum=60, o_count=4, o_ovf=0.
//   - VEC_LEN=64, 64 beats of +16129 (127*127), i_last=0, ACC_WIDTH=24
//     -> auto-close; o_sum=1032256, o_count=64, o_ovf=0.
//   - ACC_WIDTH=16: beats 32767, 1, -5 -> o_sum=32762 (clamped then subtracted), o_ovf=1;
//     the next vector {2} -> o_sum=2, o_ovf=0.
//   - Single-beat vector -128*... = -16384 with i_last=1 -> DONE directly;
//     o_sum=-16384, o_count=1; o_ready=0 in DONE.
//   - Hold i_ready=0 for 5 cycles in DONE with i_valid=1 toggling i_prod
//     -> outputs stable, o_ready=0, nothing accepted; i_ready=1 -> o_valid falls, o_ready=1 next cycle.
//   - Assert i_rst for 1 cycle after 3 of 5 beats
//     -> all outputs 0 immediately; the next 2-beat vector {5,6,last} yields o_sum=11, o_count=2.

Source files
------------

// File: rtl/alm_product_accumulator_pkg.sv
// Shared types and default widths for the ALM product accumulator slice.
package alm_product_accumulator_pkg;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ACCUM,
        ACC_DONE
    } acc_state_t;

    localparam int unsigned ALM_PROD_WIDTH = 16;
    localparam int unsigned ALM_ACC_WIDTH  = 24;
    localparam int unsigned ALM_VEC_LEN    = 64;

endpackage

// File: rtl/alm_product_accumulator_if.sv
// Product stream in, vector result out; both valid/ready.
interface alm_product_accumulator_if
    import alm_product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = ALM_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = ALM_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH  = $clog2(ALM_VEC_LEN + 1)
);
    logic signed [PROD_WIDTH-1:0] i_prod;
    logic                         i_valid;
    logic                         i_last;
    logic                         o_ready;
    logic signed [ACC_WIDTH-1:0]  o_sum;
    logic [CNT_WIDTH-1:0]         o_count;
    logic                         o_ovf;
    logic                         o_valid;
    logic                         i_ready;

    modport master (
        output i_prod, i_valid, i_last, i_ready,
        input  o_ready, o_sum, o_count, o_ovf, o_valid
    );

    modport slave (
        input  i_prod, i_valid, i_last, i_ready,
        output o_ready, o_sum, o_count, o_ovf, o_valid
    );
endinterface

// File: rtl/alm_sat_add.sv
// Combinational signed saturating adder: sum = clamp(a + b), sat flags a clamp.
module alm_sat_add #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sat
);
    localparam int unsigned EXT_W = ACC_W + 1;

    logic signed [EXT_W-1:0] a_ext;
    logic signed [EXT_W-1:0] b_ext;
    logic signed [EXT_W-1:0] full;

    // One guard bit is enough: both operands fit in ACC_W bits.
    assign a_ext = {a[ACC_W-1], a};
    assign b_ext = {{(EXT_W - IN_W){b[IN_W-1]}}, b};
    assign full  = a_ext + b_ext;

    // Guard bit disagreeing with the MSB means the true sum left the ACC_W range.
    always_comb begin
        sum = full[ACC_W-1:0];
        sat = 1'b0;
        if (full[EXT_W-1] != full[ACC_W-1]) begin
            sat = 1'b1;
            sum = full[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/alm_product_accumulator.sv
// Streaming saturating dot-product accumulator with one result per vector.
module alm_product_accumulator
    import alm_product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = ALM_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = ALM_ACC_WIDTH,
    parameter int unsigned VEC_LEN    = ALM_VEC_LEN,
    parameter int unsigned CNT_WIDTH  = $clog2(VEC_LEN + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    alm_product_accumulator_if.slave bus
);
    acc_state_t                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_base, add_sum;
    logic [CNT_WIDTH-1:0]        count_q, count_d, count_base, count_inc;
    logic                        ovf_q, ovf_d, ovf_base, add_sat;
    logic                        ready_q, valid_q;
    logic                        accept, closes;

    // A beat taken in IDLE starts a fresh vector, so its operands come from zero.
    assign acc_base   = (state_q == ACC_IDLE) ? '0 : acc_q;
    assign count_base = (state_q == ACC_IDLE) ? '0 : count_q;
    assign ovf_base   = (state_q == ACC_IDLE) ? 1'b0 : ovf_q;
    assign count_inc  = count_base + CNT_WIDTH'(1);
    assign accept     = bus.i_valid && ready_q;
    assign closes     = bus.i_last || (count_inc == CNT_WIDTH'(VEC_LEN));

    alm_sat_add #(
        .IN_W  (PROD_WIDTH),
        .ACC_W (ACC_WIDTH)
    ) u_sat_add (
        .a   (acc_base),
        .b   (bus.i_prod),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC_IDLE, ACC_ACCUM: begin
                if (accept) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    ovf_d   = ovf_base | add_sat;
                    state_d = closes ? ACC_DONE : ACC_ACCUM;
                end
            end
            ACC_DONE: begin
                if (bus.i_ready) begin
                    state_d = ACC_IDLE;
                end
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    // State and output registers; handshake flags are precomputed from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ACC_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ready_q <= (state_d != ACC_DONE);
            valid_q <= (state_d == ACC_DONE);
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sum   = acc_q;
    assign bus.o_count = count_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_alm_product_accumulator.sv
// Bench for alm_product_accumulator: a 24-bit and a 16-bit accumulator side by side.
module tb_alm_product_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alm_product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(7)) ifa ();
    alm_product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(7)) ifb ();

    alm_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .VEC_LEN(64)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    alm_product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(16), .VEC_LEN(64)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    // Bench-side drive, index 0 -> dut_a, 1 -> dut_b.
    logic [15:0] d_prod  [2];
    logic        d_valid [2];
    logic        d_last  [2];
    logic        d_ready [2];

    assign ifa.i_prod  = d_prod[0];
    assign ifa.i_valid = d_valid[0];
    assign ifa.i_last  = d_last[0];
    assign ifa.i_ready = d_ready[0];
    assign ifb.i_prod  = d_prod[1];
    assign ifb.i_valid = d_valid[1];
    assign ifb.i_last  = d_last[1];
    assign ifb.i_ready = d_ready[1];

    typedef struct {
        int sum;
        int cnt;
        bit ovf;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int get_sum(input int s);
        return (s == 0) ? int'(ifa.o_sum) : int'(ifb.o_sum);
    endfunction
    function automatic int get_cnt(input int s);
        return (s == 0) ? int'(ifa.o_count) : int'(ifb.o_count);
    endfunction
    function automatic int get_ovf(input int s);
        return (s == 0) ? int'(ifa.o_ovf) : int'(ifb.o_ovf);
    endfunction
    function automatic int get_valid(input int s);
        return (s == 0) ? int'(ifa.o_valid) : int'(ifb.o_valid);
    endfunction
    function automatic int get_ready(input int s);
        return (s == 0) ? int'(ifa.o_ready) : int'(ifb.o_ready);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: running sum clamped to the signed w-bit range after every beat.
    function automatic exp_t model(input int prods[$], input int w);
        exp_t   r;
        longint acc = 0;
        longint mx  = (longint'(1) <<< (w - 1)) - 1;
        longint mn  = -(longint'(1) <<< (w - 1));
        r.ovf = 1'b0;
        foreach (prods[i]) begin
            acc += prods[i];
            if (acc > mx) begin acc = mx; r.ovf = 1'b1; end
            if (acc < mn) begin acc = mn; r.ovf = 1'b1; end
        end
        r.sum = int'(acc);
        r.cnt = prods.size();
        return r;
    endfunction

    // Present one beat and hold it until the DUT takes it; returns 1 ns after the accepting edge.
    task automatic send_beat(input int s, input int prod, input bit last);
        int waited = 0;
        d_prod[s]  = 16'(prod);
        d_last[s]  = last;
        d_valid[s] = 1'b1;
        forever begin
            @(negedge clk);
            if (get_ready(s) == 1) break;
            waited++;
            if (waited > 100) begin
                chk("beat_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        d_valid[s] = 1'b0;
        d_last[s]  = 1'b0;
    endtask

    // Queue the model's result, then stream the vector back to back.
    task automatic send_vec(input int s, input int prods[$], input bit use_last);
        exp_t e;
        e = model(prods, (s == 0) ? 24 : 16);
        if (s == 0) exp_a.push_back(e); else exp_b.push_back(e);
        foreach (prods[i]) send_beat(s, prods[i], use_last && (i == prods.size() - 1));
    endtask

    // Literal result right after the closing edge, then the release edge (needs i_ready=1).
    task automatic check_result(input int s, input string tag, input int sum, input int cnt, input int ovf);
        chk({tag, "_valid"}, get_valid(s), 1);
        chk({tag, "_sum"},   get_sum(s),   sum);
        chk({tag, "_count"}, get_cnt(s),   cnt);
        chk({tag, "_ovf"},   get_ovf(s),   ovf);
        chk({tag, "_ready_in_done"}, get_ready(s), 0);
    endtask

    task automatic check_release(input int s, input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"},   get_valid(s), 0);
        chk({tag, "_ready_return"}, get_ready(s), 1);
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, "_sum"},   get_sum(s),   0);
            chk({tag, "_count"}, get_cnt(s),   0);
            chk({tag, "_ovf"},   get_ovf(s),   0);
            chk({tag, "_valid"}, get_valid(s), 0);
            chk({tag, "_ready"}, get_ready(s), 0);
        end
    endtask

    // Every-cycle compare against the scoreboard, plus hold-stability while stalled.
    int  prev_sum [2];
    int  prev_cnt [2];
    int  prev_ovf [2];
    bit  prev_hold[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                prev_hold[s] = 1'b0;
            end else begin
                if (prev_hold[s]) begin
                    chk("hold_sum_stable", get_sum(s), prev_sum[s]);
                    chk("hold_count_stable", get_cnt(s), prev_cnt[s]);
                    chk("hold_ovf_stable", get_ovf(s), prev_ovf[s]);
                end
                if (get_valid(s) == 1) begin
                    chk("ready_low_while_valid", get_ready(s), 0);
                    if ((s == 0 ? exp_a.size() : exp_b.size()) == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = (s == 0) ? exp_a[0] : exp_b[0];
                        chk("model_sum", get_sum(s), e.sum);
                        chk("model_count", get_cnt(s), e.cnt);
                        chk("model_ovf", get_ovf(s), int'(e.ovf));
                        if (d_ready[s]) begin
                            if (s == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
                        end
                    end
                end
                prev_hold[s] = (get_valid(s) == 1) && !d_ready[s];
                prev_sum[s]  = get_sum(s);
                prev_cnt[s]  = get_cnt(s);
                prev_ovf[s]  = get_ovf(s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   v[$];
        exp_t m;

        for (int s = 0; s < 2; s++) begin
            d_prod[s]  = '0;
            d_valid[s] = 1'b0;
            d_last[s]  = 1'b0;
            d_ready[s] = 1'b1;
        end

        // Pin the model with hand-computed values.
        v = '{100, -50, 7, 3};
        m = model(v, 24);
        chk("model_pin_sum60", m.sum, 60);
        v = '{32767, 1, -5};
        m = model(v, 16);
        chk("model_pin_sat_sum", m.sum, 32762);
        chk("model_pin_sat_ovf", int'(m.ovf), 1);

        // Reset state.
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_ready_a", get_ready(0), 1);
        chk("post_reset_ready_b", get_ready(1), 1);

        // Four-beat vector closed by i_last.
        v = '{100, -50, 7, 3};
        send_vec(0, v, 1'b1);
        check_result(0, "vec4", 60, 4, 0);
        check_release(0, "vec4");

        // 64 beats without i_last: closes on the count.
        v = {};
        for (int i = 0; i < 64; i++) v.push_back(16129);
        send_vec(0, v, 1'b0);
        check_result(0, "autoclose", 1032256, 64, 0);
        check_release(0, "autoclose");

        // 16-bit accumulator saturates, then the next vector clears ovf.
        v = '{32767, 1, -5};
        send_vec(1, v, 1'b1);
        check_result(1, "sat", 32762, 3, 1);
        check_release(1, "sat");
        v = '{2};
        send_vec(1, v, 1'b1);
        check_result(1, "after_sat", 2, 1, 0);
        check_release(1, "after_sat");

        // Single-beat vector, then a 5-cycle stall with junk beats offered.
        v = '{-16384};
        send_vec(0, v, 1'b1);
        d_ready[0] = 1'b0;
        check_result(0, "single", -16384, 1, 0);
        for (int i = 0; i < 5; i++) begin
            d_valid[0] = 1'b1;
            d_prod[0]  = 16'($urandom_range(0, 65535));
            d_last[0]  = 1'(i & 1);
            @(posedge clk);
            #1;
            chk("stall_ready", get_ready(0), 0);
            chk("stall_valid", get_valid(0), 1);
            chk("stall_sum", get_sum(0), -16384);
            chk("stall_count", get_cnt(0), 1);
        end
        d_valid[0] = 1'b0;
        d_last[0]  = 1'b0;
        d_ready[0] = 1'b1;
        check_release(0, "stall");

        // Zero products count as beats; nothing from the stall leaked in.
        v = '{0, 0, 9};
        send_vec(0, v, 1'b1);
        check_result(0, "zeros", 9, 3, 0);
        check_release(0, "zeros");

        // Reset mid-vector discards the partial sum.
        send_beat(0, 1000, 1'b0);
        send_beat(0, 2000, 1'b0);
        send_beat(0, 3000, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_ready_back", get_ready(0), 1);
        v = '{5, 6};
        send_vec(0, v, 1'b1);
        check_result(0, "post_reset_vec", 11, 2, 0);
        check_release(0, "post_reset_vec");

        repeat (3) @(posedge clk);
        chk("scoreboard_a_empty", exp_a.size(), 0);
        chk("scoreboard_b_empty", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
